mem_port_arbiter: RTL and testbench

//   Shares one single-ported unified memory between the pipeline's instruction fetch (IF) port and its data (MEM-stage) port.

---
 rtl/mem_port_arbiter.sv | 163 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ==========================================================================
// mem_port_arbiter: shares one single-ported memory between IF and MEM ports
// Rev 1.0
// ==========================================================================
module mem_port_arbiter #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_req,
  input  logic [DM_ADDRESS-1:0] if_addr,
  output logic [DATA_W-1:0]     if_rdata,
  output logic                  if_valid,
  output logic                  if_stall,
  input  logic                  dm_req,
  input  logic                  dm_we,
  input  logic [DM_ADDRESS-1:0] dm_addr,
  input  logic [DATA_W-1:0]     dm_wdata,
  input  logic [2:0]            dm_funct3,
  output logic [DATA_W-1:0]     dm_rdata,
  output logic                  dm_valid,
  output logic                  dm_stall,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [DM_ADDRESS-1:0] mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [2:0]            mem_funct3,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic                  busy
);

  localparam int          LAT_W    = $clog2(MEM_LAT + 1);
  localparam int          STARVE_W = $clog2(STARVE_MAX + 1);
  localparam logic [2:0]  F3_WORD  = 3'b010;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic                  owner_dm_q, owner_dm_d;
  logic                  we_q, we_d;
  logic [DM_ADDRESS-1:0] addr_q, addr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [LAT_W-1:0]      lat_cnt_q, lat_cnt_d;
  logic [STARVE_W-1:0]   starve_cnt_q, starve_cnt_d;
  logic [DATA_W-1:0]     if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]     dm_rdata_q, dm_rdata_d;
  logic                  grant_dm;

  // Data wins unless the fetch port has already lost STARVE_MAX grants in a row.
  assign grant_dm = dm_req && !(if_req && (starve_cnt_q == STARVE_W'(STARVE_MAX)));

  always_comb begin
    state_d      = state_q;
    owner_dm_d   = owner_dm_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    funct3_d     = funct3_q;
    lat_cnt_d    = lat_cnt_q;
    starve_cnt_d = starve_cnt_q;
    if_rdata_d   = if_rdata_q;
    dm_rdata_d   = dm_rdata_q;

    case (state_q)
      S_IDLE: begin
        if (grant_dm) begin
          owner_dm_d = 1'b1;
          we_d       = dm_we;
          addr_d     = dm_addr;
          wdata_d    = dm_wdata;
          funct3_d   = dm_funct3;
          state_d    = S_ISSUE;
          if (!if_req) begin
            starve_cnt_d = '0;
          end else if (starve_cnt_q != STARVE_W'(STARVE_MAX)) begin
            starve_cnt_d = starve_cnt_q + STARVE_W'(1);
          end
        end else if (if_req) begin
          owner_dm_d   = 1'b0;
          we_d         = 1'b0;
          addr_d       = if_addr;
          wdata_d      = '0;
          funct3_d     = F3_WORD;
          starve_cnt_d = '0;
          state_d      = S_ISSUE;
        end
      end
      S_ISSUE: begin
        lat_cnt_d = LAT_W'(MEM_LAT);
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        lat_cnt_d = lat_cnt_q - LAT_W'(1);
        if (lat_cnt_q == LAT_W'(1)) begin
          state_d = S_RESP;
          if (owner_dm_q && !we_q) begin
            dm_rdata_d = mem_rdata;
          end else if (!owner_dm_q) begin
            if_rdata_d = mem_rdata;
          end
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      owner_dm_q   <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      funct3_q     <= '0;
      lat_cnt_q    <= '0;
      starve_cnt_q <= '0;
      if_rdata_q   <= '0;
      dm_rdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      owner_dm_q   <= owner_dm_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      funct3_q     <= funct3_d;
      lat_cnt_q    <= lat_cnt_d;
      starve_cnt_q <= starve_cnt_d;
      if_rdata_q   <= if_rdata_d;
      dm_rdata_q   <= dm_rdata_d;
    end
  end

  assign mem_en     = (state_q == S_ISSUE);
  assign mem_we     = mem_en && owner_dm_q && we_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign mem_funct3 = funct3_q;

  assign if_valid   = (state_q == S_RESP) && !owner_dm_q;
  assign dm_valid   = (state_q == S_RESP) && owner_dm_q;
  assign if_rdata   = if_rdata_q;
  assign dm_rdata   = dm_rdata_q;
  assign if_stall   = if_req && !if_valid;
  assign dm_stall   = dm_req && !dm_valid;
  assign busy       = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ==========================================================================
// tb_mem_port_arbiter: directed stimulus against a cycle-arithmetic model
// Rev 1.0
// ==========================================================================
module tb_mem_port_arbiter;

  localparam int DM_ADDRESS = 9;
  localparam int DATA_W     = 32;
  localparam int MEM_LAT    = 2;
  localparam int STARVE_MAX = 4;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  if_req;
  logic [DM_ADDRESS-1:0] if_addr;
  logic [DATA_W-1:0]     if_rdata;
  logic                  if_valid;
  logic                  if_stall;
  logic                  dm_req;
  logic                  dm_we;
  logic [DM_ADDRESS-1:0] dm_addr;
  logic [DATA_W-1:0]     dm_wdata;
  logic [2:0]            dm_funct3;
  logic [DATA_W-1:0]     dm_rdata;
  logic                  dm_valid;
  logic                  dm_stall;
  logic                  mem_en;
  logic                  mem_we;
  logic [DM_ADDRESS-1:0] mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [2:0]            mem_funct3;
  logic [DATA_W-1:0]     mem_rdata;
  logic                  busy;

  mem_port_arbiter #(
    .DM_ADDRESS(DM_ADDRESS), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid), .if_stall(if_stall),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_funct3(dm_funct3),
    .dm_rdata(dm_rdata), .dm_valid(dm_valid), .dm_stall(dm_stall),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_funct3(mem_funct3), .mem_rdata(mem_rdata), .busy(busy)
  );

  initial forever #5 clk = ~clk;

  int n_err = 0;
  int n_chk = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Memory: word-addressed store; read data is only correct in cycle mem_en+MEM_LAT.
  logic [31:0] mem_words [0:127];
  int          rd_due = -1;
  logic [6:0]  rd_idx = '0;
  always @(negedge clk) begin
    if (mem_en === 1'b1) begin
      if (mem_we === 1'b1) mem_words[mem_addr[8:2]] = mem_wdata;
      else begin
        rd_due = cyc + MEM_LAT;
        rd_idx = mem_addr[8:2];
      end
    end
    mem_rdata = (cyc == rd_due) ? mem_words[rd_idx] : (32'hBAD0_0000 ^ 32'(cyc));
  end

  // Model: one transaction at a time, granted at cycle m_g, timed by arithmetic on m_g.
  bit          chk_on = 1'b0;
  bit          m_act  = 1'b0;
  int          m_g    = 0;
  bit          m_dm, m_we;
  logic [8:0]  m_addr;
  logic [31:0] m_wdata;
  logic [2:0]  m_f3;
  int          m_starve = 0;
  logic [31:0] e_if_rd = '0, e_dm_rd = '0;
  bit          e_en, e_ifv, e_dmv;

  always @(negedge clk) begin
    if (chk_on) begin
      e_en  = m_act && (cyc == m_g + 1);
      e_ifv = m_act && !m_dm && (cyc == m_g + MEM_LAT + 2);
      e_dmv = m_act && m_dm && (cyc == m_g + MEM_LAT + 2);
      chk("busy", busy, m_act);
      chk("mem_en", mem_en, e_en);
      chk("if_valid", if_valid, e_ifv);
      chk("dm_valid", dm_valid, e_dmv);
      chk("if_stall", if_stall, if_req && !e_ifv);
      chk("dm_stall", dm_stall, dm_req && !e_dmv);
      chk("if_rdata", if_rdata, e_if_rd);
      chk("dm_rdata", dm_rdata, e_dm_rd);
      if (e_en) begin
        chk("mem_addr", mem_addr, m_addr);
        chk("mem_funct3", mem_funct3, m_dm ? m_f3 : 3'b010);
        chk("mem_we", mem_we, m_dm && m_we);
        if (m_dm && m_we) chk("mem_wdata", mem_wdata, m_wdata);
      end

      if (reset === 1'b0) begin
        m_act = 1'b0; m_starve = 0; e_if_rd = '0; e_dm_rd = '0;
      end else if (m_act) begin
        if (cyc == m_g + MEM_LAT + 1 && !(m_dm && m_we)) begin
          if (m_dm) e_dm_rd = mem_words[m_addr[8:2]];
          else      e_if_rd = mem_words[m_addr[8:2]];
        end
        if (cyc == m_g + MEM_LAT + 2) m_act = 1'b0;
      end else if (dm_req && !(if_req && m_starve == STARVE_MAX)) begin
        m_act = 1'b1; m_g = cyc; m_dm = 1'b1; m_we = dm_we;
        m_addr = dm_addr; m_wdata = dm_wdata; m_f3 = dm_funct3;
        m_starve = !if_req ? 0 : (m_starve < STARVE_MAX ? m_starve + 1 : STARVE_MAX);
      end else if (if_req) begin
        m_act = 1'b1; m_g = cyc; m_dm = 1'b0; m_we = 1'b0;
        m_addr = if_addr; m_wdata = '0; m_f3 = 3'b010;
        m_starve = 0;
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  // Cycles are counted from the call (the cycle the request is first presented).
  task automatic wait_valid(input bit dm, input int max, output int lat, output int en_at);
    lat = -1; en_at = -1;
    for (int k = 0; k < max; k++) begin
      @(negedge clk);
      if (mem_en === 1'b1 && en_at < 0) en_at = k;
      if ((dm ? dm_valid : if_valid) === 1'b1) begin
        lat = k;
        break;
      end
      @(posedge clk); #1;
    end
    if (lat < 0) begin
      n_chk++; n_err++;
      $display("FAIL timeout: no %s valid within %0d cycles", dm ? "dm" : "if", max);
    end
  endtask

  int lat, en_at;

  initial begin
    reset = 1'b0; if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_we = 1'b0;
    dm_addr = '0; dm_wdata = '0; dm_funct3 = '0;
    for (int i = 0; i < 128; i++) mem_words[i] = 32'hA500_0000 | 32'(i << 2);

    repeat (2) @(posedge clk);
    #1 chk_on = 1'b1;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_valids", {if_valid, dm_valid}, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_dm_rdata", dm_rdata, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_mem_funct3", mem_funct3, 0);
    next_cycle();
    reset = 1'b1;

    // Single fetch
    if_req = 1'b1; if_addr = 9'h010;
    wait_valid(1'b0, 20, lat, en_at);
    chk("t1_latency", lat, 4);
    chk("t1_mem_en_cycle", en_at, 1);
    chk("t1_if_rdata", if_rdata, 32'hA500_0010);
    chk("t1_if_stall_at_valid", if_stall, 0);
    next_cycle();
    if_req = 1'b0;

    // Store then load of the same word
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 9'h040; dm_wdata = 32'hDEAD_BEEF; dm_funct3 = 3'b010;
    wait_valid(1'b1, 20, lat, en_at);
    chk("t2_store_latency", lat, 4);
    chk("t2_store_en_cycle", en_at, 1);
    chk("t2_dm_rdata_kept", dm_rdata, 0);
    next_cycle();
    dm_we = 1'b0;
    wait_valid(1'b1, 20, lat, en_at);
    chk("t2_load_latency", lat, 4);
    chk("t2_load_data", dm_rdata, 32'hDEAD_BEEF);
    next_cycle();
    dm_req = 1'b0;

    // Simultaneous: DM first, IF in the following IDLE (4 cycles after dm_valid+1)
    if_req = 1'b1; if_addr = 9'h024; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 9'h008;
    wait_valid(1'b1, 20, lat, en_at);
    chk("t3_dm_latency", lat, 4);
    chk("t3_dm_rdata", dm_rdata, 32'hA500_0008);
    next_cycle();
    dm_req = 1'b0;
    wait_valid(1'b0, 20, lat, en_at);
    chk("t3_if_latency", lat, 4);
    chk("t3_if_rdata", if_rdata, 32'hA500_0024);
    next_cycle();
    if_req = 1'b0;

    // Starvation: two rounds of 4 DM grants then 1 IF grant, both ports always requesting
    if_req = 1'b1; if_addr = 9'h030;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 4; i++) begin
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 9'(9'h100 + 4 * (r * 4 + i));
        wait_valid(1'b1, 20, lat, en_at);
        chk("t4_dm_latency", lat, 4);
        chk("t4_dm_rdata", dm_rdata, 32'hA500_0100 + 32'(4 * (r * 4 + i)));
        next_cycle();
      end
      wait_valid(1'b0, 20, lat, en_at);
      chk("t4_if_fifth_grant", lat, 4);
      chk("t4_if_rdata", if_rdata, 32'hA500_0030);
      next_cycle();
    end
    dm_req = 1'b0; if_req = 1'b0;

    // Reset during WAIT aborts the load
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 9'h0C0;
    next_cycle();
    next_cycle();
    reset = 1'b0; dm_req = 1'b0;
    next_cycle();
    reset = 1'b1;
    @(negedge clk);
    chk("t5_busy", busy, 0);
    chk("t5_mem_en", mem_en, 0);
    chk("t5_dm_valid", dm_valid, 0);
    chk("t5_dm_rdata_cleared", dm_rdata, 0);
    next_cycle();
    dm_req = 1'b1;
    wait_valid(1'b1, 20, lat, en_at);
    chk("t5_retry_latency", lat, 4);
    chk("t5_retry_rdata", dm_rdata, 32'hA500_00C0);
    next_cycle();
    dm_req = 1'b0;

    // Idle
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("t6_idle", {mem_en, busy, if_stall, dm_stall}, 0);
      next_cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
